// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the WISC fetch front end.
package fetch_stage_pkg;

   localparam int WORD_W  = 16;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 11;

   localparam logic [4:0]        HALT_OPC     = 5'b00000;
   localparam logic [WORD_W-1:0] PC_INC       = 16'd2;
   localparam logic [WORD_W-1:0] RESET_PC_DEF = 16'h0000;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc2;
   } id_entry_t;

   function automatic logic is_halt(input logic [WORD_W-1:0] instr);
      return (instr[OPC_MSB:OPC_LSB] == HALT_OPC);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO; flush empties it, and push is honoured while
// full only when a pop happens in the same cycle.
module fetch_queue #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         empty,
   output logic         full
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == 2'd0);
   assign full  = (count_q == 2'd2);

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch front end: PC, credit-limited imem requests, 2-entry
// decode queue, redirect flush and HALT stop. FETCH_ALIGN_CHECK_EN rejects odd redirects.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int                MAX_OUT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              id_valid,
   output logic [WORD_W-1:0] id_instr,
   output logic [WORD_W-1:0] id_pc2,
   input  logic              id_ready,
   output logic              halted,
   output logic              err
);

   localparam logic [2:0] MAX_OUT_L = 3'(MAX_OUT);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [1:0]        drop_q, drop_d;
   logic              halt_seen_q, halt_seen_d;
   logic              halted_q, halted_d;
   logic              err_q, err_d;

   logic              redir_go, redir_bad;
   logic [WORD_W-1:0] redir_target;
   logic              unused_bits;

   logic              accept, resp_ok, resp_keep, id_pop;
   logic [2:0]        credit_used;

   logic [WORD_W-1:0] tag_head;
   logic [1:0]        tag_count;
   logic              tag_empty, tag_full;

   id_entry_t         iq_push_data, iq_head;
   logic [1:0]        iq_count;
   logic              iq_empty, iq_full;

`ifdef FETCH_ALIGN_CHECK_EN
   assign redir_bad    = redirect && redirect_pc[0];
   assign redir_go     = redirect && !redirect_pc[0];
   assign redir_target = redirect_pc;
   assign unused_bits  = iq_full ^ tag_full;
`else
   assign redir_bad    = 1'b0;
   assign redir_go     = redirect;
   assign redir_target = {redirect_pc[WORD_W-1:1], 1'b0};
   assign unused_bits  = iq_full ^ tag_full ^ redirect_pc[0];
`endif

   // Decode handshake: the head transfers on every cycle where id_valid and
   // id_ready are both high; id_valid never depends on id_ready.
   assign id_valid = !iq_empty;
   assign id_instr = iq_head.instr;
   assign id_pc2   = iq_head.pc2;
   assign id_pop   = id_valid && id_ready;

   // Outstanding requests are exactly the tags awaiting a response. A head
   // leaving this cycle frees its credit, which sustains one fetch per cycle.
   assign credit_used = {1'b0, tag_count} + {1'b0, iq_count} - {2'b00, id_pop};
   assign imem_req    = rst && !halt_seen_q && !redir_go && (credit_used < MAX_OUT_L);
   assign imem_addr   = pc_q;
   assign accept      = imem_req && imem_gnt;

   assign resp_ok   = imem_rvalid && !tag_empty;
   assign resp_keep = resp_ok && (drop_q == 2'd0) && !halt_seen_q && !redir_go;

   assign iq_push_data = '{instr: imem_rdata, pc2: tag_head};

   fetch_queue #(.W(WORD_W)) u_tag_q (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (pc_q + PC_INC),
      .pop       (resp_ok),
      .flush     (1'b0),
      .head      (tag_head),
      .count     (tag_count),
      .empty     (tag_empty),
      .full      (tag_full)
   );

   fetch_queue #(.W(2*WORD_W)) u_instr_q (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_keep),
      .push_data (iq_push_data),
      .pop       (id_pop),
      .flush     (redir_go),
      .head      (iq_head),
      .count     (iq_count),
      .empty     (iq_empty),
      .full      (iq_full)
   );

   always_comb begin
      pc_d        = pc_q;
      drop_d      = drop_q;
      halt_seen_d = halt_seen_q;
      halted_d    = halted_q;
      err_d       = err_q | (imem_rvalid && tag_empty) | (imem_gnt && !imem_req) | redir_bad;

      if (redir_go) begin
         pc_d        = redir_target;
         // Every in-flight request is now stale, except one answered this cycle.
         drop_d      = tag_count - {1'b0, resp_ok};
         halt_seen_d = 1'b0;
         halted_d    = 1'b0;
      end else begin
         if (accept) begin
            pc_d = pc_q + PC_INC;
         end
         if (resp_ok && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
         end
         if (resp_keep && is_halt(imem_rdata)) begin
            halt_seen_d = 1'b1;
         end
         if (id_pop && is_halt(iq_head.instr)) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         drop_q      <= 2'd0;
         halt_seen_q <= 1'b0;
         halted_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         halt_seen_q <= halt_seen_d;
         halted_q    <= halted_d;
         err_q       <= err_d;
      end
   end

   assign halted = halted_q;
   assign err    = err_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipelined instruction-fetch front end for the 16-bit WISC core.
- Owns the PC and issues requests to instruction memory, which may have variable latency.
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute and stops fetching at HALT (opcode bits [15:11] == 5'b00000).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MAX_OUT, 2, credit limit on in-flight requests plus buffered instructions. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  16  fetch address (current PC).
- imem_gnt  in  1  memory accepted the request this cycle. Only meaningful while imem_req is high.
- imem_rvalid  in  1  instruction data valid. Responses return in request order.
- imem_rdata  in  16  returned instruction word.
- redirect  in  1  execute resolved a taken branch or jump; flush and refetch.
- redirect_pc  in  16  redirect target.
- id_valid  out  1  instruction available to decode.
- id_instr  out  16  instruction at the queue head.
- id_pc2  out  16  address of that instruction + 2.
- id_ready  in  1  decode accepts the head this cycle.
- halted  out  1  HALT has been handed to decode.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst low, asynchronous): PC = RESET_PC; outstanding = 0; drop_cnt = 0; queue empty; halt_seen = 0. All outputs read 0 except imem_addr, which equals RESET_PC.
- Credit rule: imem_req = !halt_seen && !redirect && (outstanding + q_count < MAX_OUT). imem_addr = PC.
- Request accept (imem_req && imem_gnt):
  - PC <= PC + 2, wrapping mod 2^16 (16'hFFFE -> 16'h0000).
  - Push PC + 2 into the 2-entry tag queue; outstanding += 1.
- Response (imem_rvalid):
  - Pop the tag queue; outstanding -= 1.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Else if halt_seen: discard the response.
  - Else: push {rdata, tag} into the instruction queue. If rdata[15:11] == 0, set halt_seen.
- Decode handshake:
  - id_valid = !q_empty; id_instr and id_pc2 come from the queue head.
  - Head pops on id_valid && id_ready.
  - A push and a pop in the same cycle are both honoured.
  - The credit rule guarantees the queue never overflows.
- Halted flag: halted is set on the pop of an instruction with [15:11] == 0 and is sticky until reset or redirect.
- Redirect (highest priority, single cycle):
  - PC <= redirect_pc.
  - Instruction queue cleared.
  - drop_cnt <= outstanding minus (1 if a response arrives that same cycle).
  - Tag queue keeps its in-flight entries; they are popped as responses drain.
  - halt_seen and halted cleared.
  - imem_req is held low that cycle, so no accept coincides with a redirect.
  - id_valid stays as registered that cycle; decode must ignore it when it issued the redirect.
- Latency: with a zero-wait memory (gnt same cycle, rvalid next cycle), an instruction is presented on id_valid 2 cycles after its request. Sustained throughput is 1 instruction/cycle when MAX_OUT = 2.
- err (sticky until reset): set on imem_rvalid while outstanding == 0, or on imem_gnt while imem_req is low.
- Reset asserted mid-transaction: everything clears immediately. Responses that arrive after reset releases trigger err, so memory is expected to be reset together with this block.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[0] == 1 sets err.
  - The redirect is ignored: PC holds, no flush.
- Undefined: redirect_pc[0] is forced to 0 and no error is raised.

Decomposition:
- Shared package holds:
  - WORD_W = 16.
  - HALT_OPC = 5'b00000 and the OPC field position [15:11].
  - PC_INC = 2.
  - RESET_PC default.
- One natural sub-module, fetch_queue: a 2-entry synchronous FIFO with push, pop, flush, count, empty and full, parameterised by width. It is instantiated twice: for tags (16 bits) and for instruction+tag (32 bits).

Test Plan:
- Zero-wait memory returning 16'h4000 for every word, id_ready = 1:
  - id_valid rises at cycle 2.
  - id_pc2 = 2, 4, 6, ... on consecutive cycles.
- id_ready held low for 5 cycles:
  - Exactly 2 instructions are buffered and imem_req drops.
  - On release, instructions drain in order with no loss or duplication.
- Redirect to 16'h0100 with 2 requests outstanding:
  - The next 2 responses are dropped.
  - First id_pc2 after the flush is 16'h0102.
  - err stays 0.
- Memory returns 16'h0000 at address 16'h0006:
  - imem_req stays low after the halt word is accepted.
  - The halt word is presented with id_pc2 = 8; later responses are dropped.
  - halted = 1 after the pop.
  - A subsequent redirect clears halted and resumes fetching.
- Spurious imem_rvalid with nothing outstanding: err = 1 and stays set until rst is asserted low.
- With FETCH_ALIGN_CHECK_EN, redirect_pc = 16'h0101: err = 1 and PC is unchanged. Without the macro, the next imem_addr is 16'h0100.
